// File: rtl/rca_arbiter.sv
// Round-robin arbiter/sequencer sharing one rca adder among num_req requesters.
// One operation in flight: IDLE accepts, EXEC captures the adder result, RESP returns it.
module rca_arbiter #(
   parameter int bit_width = 16,
   parameter int num_req   = 4,
   parameter int id_w      = $clog2(num_req)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [num_req-1:0]            req_valid,
   output logic [num_req-1:0]            req_ready,
   input  logic [num_req*bit_width-1:0]  req_a,
   input  logic [num_req*bit_width-1:0]  req_b,
   input  logic [num_req-1:0]            req_sub,
   output logic [bit_width-1:0]          add_a,
   output logic [bit_width-1:0]          add_b,
   output logic                          add_carry_in,
   input  logic [bit_width-1:0]          add_s,
   input  logic                          add_carry_out,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [id_w-1:0]               rsp_id,
   output logic [bit_width-1:0]          rsp_s,
   output logic                          rsp_carry_out,
   output logic                          rsp_ovf,
   output logic                          busy
);

   localparam int msb = bit_width - 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t                state, state_next;
   logic [id_w-1:0]       last_grant;
   logic [id_w-1:0]       grant;
   logic                  grant_valid;
   logic                  accept;
   int                    cand;
   logic [bit_width-1:0]  op_a, op_b;
   logic                  op_sub;
   logic [id_w-1:0]       op_id;
   logic                  ovf;

   // Search starts one past the last winner, so the last winner has lowest priority.
   always_comb begin : grant_search
      // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
      grant       = '0;
      grant_valid = 1'b0;
      cand        = 0;
      for (int k = 1; k <= num_req; k++) begin
         cand = (int'(last_grant) + k) % num_req;
         if (!grant_valid && req_valid[id_w'(cand)]) begin
            grant_valid = 1'b1;
            grant       = id_w'(cand);
         end
      end
   end

   assign accept = (state == IDLE) && grant_valid;

   always_ff @(posedge clk) begin : state_reg
      // NOTE: sequential state uses non-blocking assignments; reset is tested inside the clocked block, so it is synchronous.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin : next_state
      state_next = state;
      case (state)
         IDLE:    if (grant_valid) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin : outputs
      req_ready = '0;
      if (state == IDLE && grant_valid && !rst) req_ready[grant] = 1'b1;
      busy = (state != IDLE);
   end

   // Adder inputs come straight from registers, so they only move on an accept edge.
   assign add_a        = op_a;
   assign add_b        = op_b;
   assign add_carry_in = op_sub;

   // Subtract overflows when the operands differ in sign and the result sign leaves A's.
   assign ovf = op_sub ? ((op_a[msb] != op_b[msb]) && (add_s[msb] != op_a[msb]))
                       : ((op_a[msb] == op_b[msb]) && (add_s[msb] != op_a[msb]));

   always_ff @(posedge clk) begin : datapath
      if (rst) begin
         op_a          <= '0;
         op_b          <= '0;
         op_sub        <= 1'b0;
         op_id         <= '0;
         last_grant    <= id_w'(num_req - 1);
         rsp_valid     <= 1'b0;
         rsp_id        <= '0;
         rsp_s         <= '0;
         rsp_carry_out <= 1'b0;
         rsp_ovf       <= 1'b0;
      end else begin
         if (accept) begin
            op_a       <= req_a[grant*bit_width +: bit_width];
            op_b       <= req_b[grant*bit_width +: bit_width];
            op_sub     <= req_sub[grant];
            op_id      <= grant;
            last_grant <= grant;
         end
         if (state == EXEC) begin
            rsp_s         <= add_s;
            rsp_carry_out <= add_carry_out;
            rsp_ovf       <= ovf;
            rsp_id        <= op_id;
            rsp_valid     <= 1'b1;
         end
         if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
      end
   end

endmodule
